// File: rtl/controle_pipeline.sv
// Pipelined control unit: ID decode, ID/EX -> EX/MEM -> MEM/WB control bundle, hazard detection,
// forwarding selects and saturating hazard counters. Forwarding is enabled by CONTROLE_FORWARD_EN.
module controle_pipeline #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [RA_W-1:0] id_rd,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic            branch_taken,
  output logic [1:0]      ex_ALUop,
  output logic            ex_ALUSrc,
  output logic            ex_branch,
  output logic [6:0]      ex_funct7,
  output logic [2:0]      ex_funct3,
  output logic            mem_sinal_leitura,
  output logic            mem_sinal_escrita,
  output logic            wb_reg_escrita,
  output logic            wb_MemToReg,
  output logic [RA_W-1:0] wb_rd,
  output logic            stall_if_id,
  output logic            flush_if_id,
  output logic [1:0]      forward_a,
  output logic [1:0]      forward_b,
  output logic [CNT_W-1:0] cnt_bolhas,
  output logic [CNT_W-1:0] cnt_flush
);

  localparam logic [6:0] OP_LH  = 7'b0000011;
  localparam logic [6:0] OP_SH  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BNE = 7'b1100011;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
  } ctrl_t;

  ctrl_t id_ctrl, idex_ctrl, exmem_ctrl, memwb_ctrl;
  logic  id_known, uses_rs1, uses_rs2;
  logic  hazard;
  logic [RA_W-1:0] idex_rd, idex_rs1, idex_rs2, exmem_rd, memwb_rd;
  logic [2:0] idex_funct3;
  logic [6:0] idex_funct7;
  logic [CNT_W-1:0] bolhas_q, flush_q;

  always_comb begin
    id_ctrl  = '0;
    id_known = 1'b0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    if (id_valid) begin
      case (opcode)
        OP_LH: begin
          id_known = 1'b1; uses_rs1 = 1'b1;
          id_ctrl.mem_read = 1'b1; id_ctrl.reg_write = 1'b1;
          id_ctrl.alu_src = 1'b1;  id_ctrl.mem_to_reg = 1'b1;
        end
        OP_SH: begin
          id_known = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
          id_ctrl.mem_write = 1'b1; id_ctrl.alu_src = 1'b1;
        end
        OP_R: begin
          id_known = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
          id_ctrl.alu_op = 2'b10; id_ctrl.reg_write = 1'b1;
        end
        OP_I: begin
          id_known = 1'b1; uses_rs1 = 1'b1;
          id_ctrl.reg_write = 1'b1; id_ctrl.alu_src = 1'b1;
          if (funct3 == 3'b111)      id_ctrl.alu_op = 2'b11;
          else if (funct3 == 3'b001) id_ctrl.alu_op = 2'b10;
          else                       id_ctrl.alu_op = 2'b00;
        end
        OP_BNE: begin
          id_known = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
          id_ctrl.alu_op = 2'b01; id_ctrl.branch = 1'b1;
        end
        default: ;
      endcase
    end
  end

  function automatic logic depends(input logic [RA_W-1:0] rd, input logic u1, input logic u2,
                                   input logic [RA_W-1:0] rs1, input logic [RA_W-1:0] rs2);
    return (rd != '0) && ((u1 && (rd == rs1)) || (u2 && (rd == rs2)));
  endfunction

`ifdef CONTROLE_FORWARD_EN
  // Only a load in EX cannot be forwarded in time; everything else is bypassed.
  always_comb begin
    hazard = idex_ctrl.mem_read && depends(idex_rd, uses_rs1, uses_rs2, id_rs1, id_rs2);
    forward_a = 2'b00;
    forward_b = 2'b00;
    if (exmem_ctrl.reg_write && exmem_rd != '0 && exmem_rd == idex_rs1)      forward_a = 2'b10;
    else if (memwb_ctrl.reg_write && memwb_rd != '0 && memwb_rd == idex_rs1) forward_a = 2'b01;
    if (exmem_ctrl.reg_write && exmem_rd != '0 && exmem_rd == idex_rs2)      forward_b = 2'b10;
    else if (memwb_ctrl.reg_write && memwb_rd != '0 && memwb_rd == idex_rs2) forward_b = 2'b01;
  end
`else
  // MEM/WB is not checked: the register file writes before it is read in the same cycle.
  always_comb begin
    hazard = (idex_ctrl.reg_write && depends(idex_rd, uses_rs1, uses_rs2, id_rs1, id_rs2)) ||
             (exmem_ctrl.reg_write && depends(exmem_rd, uses_rs1, uses_rs2, id_rs1, id_rs2));
  end
  assign forward_a = 2'b00;
  assign forward_b = 2'b00;
`endif

  assign flush_if_id = branch_taken;
  assign stall_if_id = hazard && !branch_taken;

  // Source fields are stored only when used, so unused fields never trigger a forward.
  always_ff @(posedge clk) begin
    if (reset) begin
      idex_ctrl <= '0; idex_rd <= '0; idex_rs1 <= '0; idex_rs2 <= '0;
      idex_funct3 <= '0; idex_funct7 <= '0;
      exmem_ctrl <= '0; exmem_rd <= '0;
      memwb_ctrl <= '0; memwb_rd <= '0;
      bolhas_q <= '0; flush_q <= '0;
    end else begin
      exmem_ctrl <= idex_ctrl;
      exmem_rd   <= idex_rd;
      memwb_ctrl <= exmem_ctrl;
      memwb_rd   <= exmem_rd;
      if (flush_if_id || stall_if_id || !id_known) begin
        idex_ctrl <= '0; idex_rd <= '0; idex_rs1 <= '0; idex_rs2 <= '0;
        idex_funct3 <= '0; idex_funct7 <= '0;
      end else begin
        idex_ctrl   <= id_ctrl;
        idex_rd     <= id_rd;
        idex_rs1    <= uses_rs1 ? id_rs1 : '0;
        idex_rs2    <= uses_rs2 ? id_rs2 : '0;
        idex_funct3 <= funct3;
        idex_funct7 <= funct7;
      end
      if (stall_if_id && bolhas_q != '1) bolhas_q <= bolhas_q + CNT_W'(1);
      if (flush_if_id && flush_q != '1)  flush_q  <= flush_q + CNT_W'(1);
    end
  end

  assign ex_ALUop          = idex_ctrl.alu_op;
  assign ex_ALUSrc         = idex_ctrl.alu_src;
  assign ex_branch         = idex_ctrl.branch;
  assign ex_funct3         = idex_funct3;
  assign ex_funct7         = idex_funct7;
  assign mem_sinal_leitura = exmem_ctrl.mem_read;
  assign mem_sinal_escrita = exmem_ctrl.mem_write;
  assign wb_reg_escrita    = memwb_ctrl.reg_write;
  assign wb_MemToReg       = memwb_ctrl.mem_to_reg;
  assign wb_rd             = memwb_rd;
  assign cnt_bolhas        = bolhas_q;
  assign cnt_flush         = flush_q;

endmodule

// File: tb/tb_controle_pipeline.sv
// Self-checking bench for controle_pipeline: decode vector table plus hazard, forwarding,
// flush, saturation and mid-stream reset sequences. Expectations follow CONTROLE_FORWARD_EN.
module tb_controle_pipeline;

  localparam int RA_W = 5;
`ifdef CONTROLE_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam logic [6:0] OP_LH  = 7'b0000011;
  localparam logic [6:0] OP_SH  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BNE = 7'b1100011;

  logic clk = 1'b0;
  logic reset, id_valid, branch_taken;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [RA_W-1:0] id_rd, id_rs1, id_rs2;
  logic [1:0] ex_ALUop, forward_a, forward_b;
  logic ex_ALUSrc, ex_branch, mem_sinal_leitura, mem_sinal_escrita;
  logic wb_reg_escrita, wb_MemToReg, stall_if_id, flush_if_id;
  logic [6:0] ex_funct7;
  logic [2:0] ex_funct3;
  logic [RA_W-1:0] wb_rd;
  logic [15:0] cnt_bolhas, cnt_flush;

  logic [1:0] s_ALUop, s_fa, s_fb;
  logic s_ALUSrc, s_branch, s_rd, s_wr, s_rw, s_m2r, s_stall, s_flush;
  logic [6:0] s_f7;
  logic [2:0] s_f3;
  logic [RA_W-1:0] s_wb_rd;
  logic [1:0] sat_bolhas, sat_flush;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_bolhas = 0;
  int exp_flush  = 0;

  always #5 clk = ~clk;

  controle_pipeline #(.RA_W(RA_W), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .opcode(opcode), .funct3(funct3),
    .funct7(funct7), .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .branch_taken(branch_taken), .ex_ALUop(ex_ALUop), .ex_ALUSrc(ex_ALUSrc),
    .ex_branch(ex_branch), .ex_funct7(ex_funct7), .ex_funct3(ex_funct3),
    .mem_sinal_leitura(mem_sinal_leitura), .mem_sinal_escrita(mem_sinal_escrita),
    .wb_reg_escrita(wb_reg_escrita), .wb_MemToReg(wb_MemToReg), .wb_rd(wb_rd),
    .stall_if_id(stall_if_id), .flush_if_id(flush_if_id), .forward_a(forward_a),
    .forward_b(forward_b), .cnt_bolhas(cnt_bolhas), .cnt_flush(cnt_flush)
  );

  // Narrow-counter instance sharing the same stimulus, used for saturation checks.
  controle_pipeline #(.RA_W(RA_W), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid), .opcode(opcode), .funct3(funct3),
    .funct7(funct7), .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .branch_taken(branch_taken), .ex_ALUop(s_ALUop), .ex_ALUSrc(s_ALUSrc),
    .ex_branch(s_branch), .ex_funct7(s_f7), .ex_funct3(s_f3),
    .mem_sinal_leitura(s_rd), .mem_sinal_escrita(s_wr),
    .wb_reg_escrita(s_rw), .wb_MemToReg(s_m2r), .wb_rd(s_wb_rd),
    .stall_if_id(s_stall), .flush_if_id(s_flush), .forward_a(s_fa),
    .forward_b(s_fb), .cnt_bolhas(sat_bolhas), .cnt_flush(sat_flush)
  );

  typedef struct {
    logic       valid;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd;
    logic [1:0] aluop;
    logic       alusrc, br, mr, mw, rw, m2r;
    logic [4:0] wbrd;
    logic [2:0] exf3;
    logic [6:0] exf7;
  } vec_t;

  vec_t vecs[10];

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [6:0] op, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic bt);
    id_valid = v; opcode = op; funct3 = f3; funct7 = f7;
    id_rd = rd; id_rs1 = rs1; id_rs2 = rs2; branch_taken = bt;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (3) tick();
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, " cnt_bolhas"}, 32'(cnt_bolhas), 32'(exp_bolhas));
    checkOutput({tag, " cnt_flush"}, 32'(cnt_flush), 32'(exp_flush));
    checkOutput({tag, " sat cnt_bolhas"}, 32'(sat_bolhas), 32'(sat3(exp_bolhas)));
    checkOutput({tag, " sat cnt_flush"}, 32'(sat_flush), 32'(sat3(exp_flush)));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " ex_ALUop"}, 32'(ex_ALUop), 32'd0);
    checkOutput({tag, " ex_ALUSrc/branch"}, 32'({ex_ALUSrc, ex_branch}), 32'd0);
    checkOutput({tag, " ex_funct"}, 32'({ex_funct7, ex_funct3}), 32'd0);
    checkOutput({tag, " mem_sinais"}, 32'({mem_sinal_leitura, mem_sinal_escrita}), 32'd0);
    checkOutput({tag, " wb ctrl"}, 32'({wb_reg_escrita, wb_MemToReg}), 32'd0);
    checkOutput({tag, " wb_rd"}, 32'(wb_rd), 32'd0);
    checkOutput({tag, " stall/flush"}, 32'({stall_if_id, flush_if_id}), 32'd0);
    checkOutput({tag, " forward"}, 32'({forward_a, forward_b}), 32'd0);
    checkCounters(tag);
  endtask

  // Producer A, optional gap of bubbles, then consumer B held in ID while it stalls.
  task automatic runPair(input string tag,
                         input logic [6:0] op_a, input logic [4:0] rd_a, input logic [4:0] rs1_a,
                         input int gap,
                         input logic [6:0] op_b, input logic [2:0] f3_b, input logic [6:0] f7_b,
                         input logic [4:0] rs1_b, input logic [4:0] rs2_b,
                         input int exp_stalls, input logic [1:0] exp_fa, input logic [1:0] exp_fb);
    int stalls = 0;
    applyStimulus(1'b1, op_a, 3'b001, 7'd0, rd_a, rs1_a, 5'd0, 1'b0);
    tick();
    for (int g = 0; g < gap; g++) begin
      idle();
      tick();
    end
    applyStimulus(1'b1, op_b, f3_b, f7_b, 5'd20, rs1_b, rs2_b, 1'b0);
    #1;
    while (stall_if_id === 1'b1 && stalls < 6) begin
      stalls++;
      tick();
      checkOutput({tag, " bubble ex ctrl"}, 32'({ex_ALUop, ex_ALUSrc, ex_branch}), 32'd0);
      checkOutput({tag, " bubble ex funct"}, 32'({ex_funct7, ex_funct3}), 32'd0);
    end
    checkOutput({tag, " stall cycles"}, 32'(stalls), 32'(exp_stalls));
    tick();
    checkOutput({tag, " consumer ex_funct"}, 32'({ex_funct7, ex_funct3}), 32'({f7_b, f3_b}));
    checkOutput({tag, " forward_a"}, 32'(forward_a), 32'(exp_fa));
    checkOutput({tag, " forward_b"}, 32'(forward_b), 32'(exp_fb));
    exp_bolhas += exp_stalls;
    checkCounters(tag);
    drain();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vecs[0] = '{1'b1, OP_LH,  3'b001, 7'h00, 5'd3,  2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3,  3'b001, 7'h00};
    vecs[1] = '{1'b1, OP_SH,  3'b001, 7'h00, 5'd4,  2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd4,  3'b001, 7'h00};
    vecs[2] = '{1'b1, OP_R,   3'b000, 7'h00, 5'd5,  2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5,  3'b000, 7'h00};
    vecs[3] = '{1'b1, OP_R,   3'b000, 7'h20, 5'd6,  2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd6,  3'b000, 7'h20};
    vecs[4] = '{1'b1, OP_I,   3'b111, 7'h00, 5'd7,  2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd7,  3'b111, 7'h00};
    vecs[5] = '{1'b1, OP_I,   3'b001, 7'h00, 5'd8,  2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd8,  3'b001, 7'h00};
    vecs[6] = '{1'b1, OP_I,   3'b000, 7'h00, 5'd9,  2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd9,  3'b000, 7'h00};
    vecs[7] = '{1'b1, OP_BNE, 3'b001, 7'h00, 5'd10, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd10, 3'b001, 7'h00};
    vecs[8] = '{1'b1, 7'h7f,  3'b101, 7'h20, 5'd11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  3'b000, 7'h00};
    vecs[9] = '{1'b0, OP_LH,  3'b001, 7'h00, 5'd12, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  3'b000, 7'h00};

    reset = 1'b1;
    idle();
    repeat (2) tick();
    checkAllZero("reset");
    reset = 1'b0;

    // Decode table: sources are x0 so no hazards between consecutive vectors.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].valid, vecs[i].opc, vecs[i].f3, vecs[i].f7, vecs[i].rd, 5'd0, 5'd0, 1'b0);
      tick();
      checkOutput($sformatf("vec%0d ex_ALUop", i), 32'(ex_ALUop), 32'(vecs[i].aluop));
      checkOutput($sformatf("vec%0d ex_ALUSrc/branch", i), 32'({ex_ALUSrc, ex_branch}),
                  32'({vecs[i].alusrc, vecs[i].br}));
      checkOutput($sformatf("vec%0d ex_funct", i), 32'({ex_funct7, ex_funct3}),
                  32'({vecs[i].exf7, vecs[i].exf3}));
      idle();
      tick();
      checkOutput($sformatf("vec%0d mem", i), 32'({mem_sinal_leitura, mem_sinal_escrita}),
                  32'({vecs[i].mr, vecs[i].mw}));
      tick();
      checkOutput($sformatf("vec%0d wb ctrl", i), 32'({wb_reg_escrita, wb_MemToReg}),
                  32'({vecs[i].rw, vecs[i].m2r}));
      checkOutput($sformatf("vec%0d wb_rd", i), 32'(wb_rd), 32'(vecs[i].wbrd));
    end
    drain();
    checkCounters("after decode");

    runPair("add5->andi", OP_R, 5'd5, 5'd1, 0, OP_I, 3'b111, 7'h00, 5'd5, 5'd0,
            FWD ? 0 : 2, FWD ? 2'b10 : 2'b00, 2'b00);
    runPair("add5-nop-andi", OP_R, 5'd5, 5'd1, 1, OP_I, 3'b111, 7'h00, 5'd5, 5'd0,
            FWD ? 0 : 1, FWD ? 2'b01 : 2'b00, 2'b00);
    runPair("add7->sub", OP_R, 5'd7, 5'd1, 0, OP_R, 3'b000, 7'h20, 5'd7, 5'd3,
            FWD ? 0 : 2, FWD ? 2'b10 : 2'b00, 2'b00);
    runPair("lh6->add", OP_LH, 5'd6, 5'd1, 0, OP_R, 3'b000, 7'h00, 5'd2, 5'd6,
            FWD ? 1 : 2, 2'b00, FWD ? 2'b01 : 2'b00);

    // Taken branch while ID holds a load-use dependent: flush wins, no bubble count.
    applyStimulus(1'b1, OP_LH, 3'b001, 7'h00, 5'd6, 5'd1, 5'd0, 1'b0);
    tick();
    applyStimulus(1'b1, OP_R, 3'b000, 7'h20, 5'd21, 5'd2, 5'd6, 1'b1);
    #1;
    checkOutput("branch flush_if_id", 32'(flush_if_id), 32'd1);
    checkOutput("branch stall_if_id", 32'(stall_if_id), 32'd0);
    tick();
    checkOutput("branch squashed ex", 32'({ex_ALUop, ex_ALUSrc, ex_funct7}), 32'd0);
    exp_flush += 1;
    checkCounters("branch");
    drain();

    for (int k = 0; k < 3; k++)
      runPair($sformatf("sat lh6->add #%0d", k), OP_LH, 5'd6, 5'd1, 0, OP_R, 3'b000, 7'h00,
              5'd2, 5'd6, FWD ? 1 : 2, 2'b00, FWD ? 2'b01 : 2'b00);
    checkOutput("sat instance holds 3", 32'(sat_bolhas), 32'd3);

    // Mid-stream reset with bundles in every stage.
    applyStimulus(1'b1, OP_R, 3'b000, 7'h00, 5'd5, 5'd1, 5'd2, 1'b0);
    tick();
    applyStimulus(1'b1, OP_LH, 3'b001, 7'h00, 5'd6, 5'd1, 5'd0, 1'b0);
    tick();
    applyStimulus(1'b1, OP_I, 3'b111, 7'h00, 5'd8, 5'd0, 5'd0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    #1;
    exp_bolhas = 0;
    exp_flush  = 0;
    checkAllZero("mid reset");
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput($sformatf("post reset wb c%0d", c), 32'({wb_reg_escrita, wb_MemToReg, wb_rd}), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
